instr_fetch_unit: RTL and testbench

Instruction fetch sequencer that produces the 8-bit instruction stream consumed by `control_unit`, the producer end of the instruction interface. It holds the program counter and issues single-beat reads to instruction memory. Each returned byte is presented downstream with a valid/ready handshake, together with its fetch address. It accepts redirects (branch/jump targets) from the execute stage and flushes any wrong-path fetch.

---
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 tb/tb_instr_fetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: keeps the fetch PC, issues single-beat reads
// to instruction memory, and presents each returned byte downstream with a
// valid/ready handshake. A redirect from execute reloads the PC. Any read
// already in flight when the redirect arrives is dropped.
//
// state | meaning
// IDLE  | parked, no request outstanding
// REQ   | read strobe high, address = fetch PC
// RESP  | memory data valid; capture it, or drop it if squashed
// ISSUE | instruction presented, waiting for the consumer
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_rdata,
  output logic [7:0]        instruction,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, ISSUE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              squash, squash_nxt;
  logic              capture;

  assign imem_rd_en = (state == REQ);
  assign imem_addr  = pc;

  // State, PC and presented-instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      squash      <= 1'b0;
      instruction <= 8'h00;
      instr_pc    <= RESET_PC;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      squash      <= squash_nxt;
      instr_valid <= (state_nxt == ISSUE);
      if (capture) begin
        instruction <= imem_rdata;
        instr_pc    <= pc;
      end
    end
  end

  // Next-state logic. A redirect overrides every other transition.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    squash_nxt = squash;
    capture    = 1'b0;
    if (redirect) begin
      pc_nxt = redirect_target;
      unique case (state)
        IDLE: ;
        REQ: begin
          squash_nxt = 1'b1;
          state_nxt  = RESP;
        end
        RESP: begin
          squash_nxt = 1'b0;
          state_nxt  = REQ;
        end
        ISSUE: state_nxt = enable ? REQ : IDLE;
        default: state_nxt = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: if (enable) state_nxt = REQ;
        REQ:  state_nxt = RESP;
        RESP: begin
          if (squash) begin
            squash_nxt = 1'b0;
            state_nxt  = REQ;
          end else begin
            capture   = 1'b1;
            pc_nxt    = pc + ADDR_W'(1);
            state_nxt = ISSUE;
          end
        end
        ISSUE: if (instr_ready) state_nxt = enable ? REQ : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a transaction-level model of the fetcher is
// compared against the DUT every cycle, with directed scenarios and a
// randomized phase. A second instance checks PC wrap from RESET_PC=FE.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0, instr_ready = 1'b0, redirect = 1'b0;
  logic [7:0] redirect_target = 8'h00;
  logic       imem_rd_en, instr_valid;
  logic [7:0] imem_addr, imem_rdata, instruction, instr_pc;

  logic       w_en = 1'b0;
  logic       w_rd_en, w_valid;
  logic [7:0] w_addr, w_rdata, w_instr, w_pc;

  logic [7:0] mem [256];
  logic [7:0] rd_q = 8'h00, w_rd_q = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  logic [15:0] hs_q[$];
  logic [7:0]  w_q[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect),
    .redirect_target(redirect_target)
  );

  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFE)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .enable(w_en),
    .imem_rd_en(w_rd_en), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .instruction(w_instr), .instr_pc(w_pc), .instr_valid(w_valid),
    .instr_ready(1'b1), .redirect(1'b0), .redirect_target(8'h00)
  );

  // Memory: data for the address strobed in the previous cycle.
  assign imem_rdata = mem[rd_q];
  assign w_rdata    = mem[w_rd_q];
  always @(posedge clk) begin
    if (imem_rd_en) rd_q <= imem_addr;
    if (w_rd_en) w_rd_q <= w_addr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a fetch in flight is tracked by its age (1 = request
  // cycle, 2 = data cycle), plus whether it is on a wrong path and whether
  // an instruction is currently held for the consumer.
  int         m_age = 0;
  bit         m_wrong = 1'b0, m_held = 1'b0;
  logic [7:0] m_pc = 8'h00, m_instr = 8'h00, m_ipc = 8'h00;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_age = 0; m_wrong = 0; m_held = 0;
      m_pc = 8'h00; m_instr = 8'h00; m_ipc = 8'h00;
    end else begin
      if (imem_rd_en) rd_cnt++;
      if (instr_valid && instr_ready && !redirect) hs_q.push_back({instruction, instr_pc});
      if (w_valid) w_q.push_back(w_pc);
      if (redirect) begin
        m_pc = redirect_target;
        if (m_age == 1) begin m_wrong = 1; m_age = 2; end
        else if (m_age == 2) begin m_wrong = 0; m_age = 1; end
        else if (m_held) begin m_held = 0; m_age = enable ? 1 : 0; end
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (m_age == 2) begin
        if (m_wrong) begin
          m_wrong = 0; m_age = 1;
        end else begin
          m_instr = mem[m_pc]; m_ipc = m_pc; m_pc = m_pc + 8'd1;
          m_age = 0; m_held = 1;
        end
      end else if (m_held) begin
        if (instr_ready) begin m_held = 0; m_age = enable ? 1 : 0; end
      end else if (enable) begin
        m_age = 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rd_en", 32'(imem_rd_en), 32'(m_age == 1));
      chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("instr_valid", 32'(instr_valid), 32'(m_held));
      chk("instruction", 32'(instruction), 32'(m_instr));
      chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
      if (instr_valid) chk("instr_matches_mem", 32'(instruction), 32'(mem[instr_pc]));
    end
  end

  task automatic step(input bit en, input bit rdy, input bit red, input logic [7:0] tgt);
    enable = en; instr_ready = rdy; redirect = red; redirect_target = tgt;
    @(negedge clk);
  endtask

  task automatic wait_valid(input bit en, input bit rdy);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (instr_valid) seen = 1;
      else step(en, rdy, 1'b0, 8'h00);
    end
    if (!seen) chk("wait_valid_timeout", 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_rd(input bit en);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (imem_rd_en) seen = 1;
      else step(en, 1'b1, 1'b0, 8'h00);
    end
    if (!seen) chk("wait_rd_timeout", 32'(imem_rd_en), 32'd1);
  endtask

  int         n;
  logic [7:0] p;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h1F; mem[1] = 8'hE3; mem[2] = 8'hC5; mem[8'h40] = 8'hA7;

    #2 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk("reset_valid", 32'(instr_valid), 32'd0);
    chk("reset_rd_en", 32'(imem_rd_en), 32'd0);
    chk("reset_addr", 32'(imem_addr), 32'h00);
    chk("reset_instr", 32'(instruction), 32'h00);
    chk("reset_ipc", 32'(instr_pc), 32'h00);

    // Streaming, one instruction every 3 cycles.
    hs_q.delete(); rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00);
      if (i == 0) chk("lat_rd_en", 32'(imem_rd_en), 32'd1);
      if (i == 1) chk("lat_not_valid", 32'(instr_valid), 32'd0);
      if (i == 2) chk("lat_valid", 32'(instr_valid), 32'd1);
    end
    chk("stream_rd_cnt", 32'(rd_cnt), 32'd3);
    chk("stream_hs_cnt", 32'(hs_q.size()), 32'd3);
    if (hs_q.size() >= 3) begin
      chk("stream_hs0", 32'(hs_q[0]), 32'h1F00);
      chk("stream_hs1", 32'(hs_q[1]), 32'hE301);
      chk("stream_hs2", 32'(hs_q[2]), 32'hC502);
    end
    repeat (6) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("park_valid", 32'(instr_valid), 32'd0);
    chk("park_rd_en", 32'(imem_rd_en), 32'd0);

    // Backpressure on the fetch from pc 4.
    wait_valid(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00);
      chk("bp_pc", 32'(instr_pc), 32'h04);
      chk("bp_instr", 32'(instruction), 32'(mem[4]));
      chk("bp_rd_en", 32'(imem_rd_en), 32'd0);
      chk("bp_valid", 32'(instr_valid), 32'd1);
    end
    n = hs_q.size();
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("bp_one_hs", 32'(hs_q.size()), 32'(n + 1));
    if (hs_q.size() > n) chk("bp_hs_pc", 32'(hs_q[n][7:0]), 32'h04);

    // Redirects in REQ, RESP and ISSUE.
    for (int k = 0; k < 3; k++) begin
      if (k == 2) wait_valid(1'b1, 1'b1);
      else wait_rd(1'b1);
      if (k == 1) step(1'b1, 1'b1, 1'b0, 8'h00);
      n = hs_q.size();
      step(1'b1, 1'b1, 1'b1, 8'h40);
      wait_valid(1'b1, 1'b0);
      chk("redir_pc", 32'(instr_pc), 32'h40);
      chk("redir_instr", 32'(instruction), 32'hA7);
      chk("redir_no_old", 32'(hs_q.size()), 32'(n));
      step(1'b1, 1'b1, 1'b0, 8'h00);
    end

    // Drop enable during RESP.
    wait_rd(1'b1);
    p = imem_addr;
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("drop_valid", 32'(instr_valid), 32'd1);
    chk("drop_pc", 32'(instr_pc), 32'(p));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk("drop_idle_rd", 32'(imem_rd_en), 32'd0);
    end
    wait_valid(1'b1, 1'b0);
    chk("resume_pc", 32'(instr_pc), 32'(8'(p + 8'd1)));

    // Asynchronous reset while presenting.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_addr", 32'(imem_addr), 32'h00);
    chk("arst_rd_en", 32'(imem_rd_en), 32'd0);
    chk("arst_ipc", 32'(instr_pc), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(1'b1, 1'b1);
    chk("arst_restart_pc", 32'(instr_pc), 32'h00);
    chk("arst_restart_instr", 32'(instruction), 32'h1F);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      step(($urandom % 8) != 0, ($urandom % 3) != 0, ($urandom % 12) == 0, 8'($urandom));

    // PC wrap on the second instance.
    w_q.delete();
    w_en = 1'b1;
    repeat (12) step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("wrap_cnt_ge3", 32'(w_q.size() >= 3), 32'd1);
    if (w_q.size() >= 3) begin
      chk("wrap_pc0", 32'(w_q[0]), 32'hFE);
      chk("wrap_pc1", 32'(w_q[1]), 32'hFF);
      chk("wrap_pc2", 32'(w_q[2]), 32'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
